// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register index, data word and writeback request.
// Index width follows the architectural register count.
package cpu_types_pkg;
  localparam int NREGS = 32;
  localparam int IDX_W = $clog2(NREGS);

  typedef logic [IDX_W-1:0] index_t;
  typedef logic [31:0]      word_t;

  typedef struct packed {
    index_t idx;
    word_t  data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for writeback requests; head is visible combinationally, push/pop take effect on the edge.
// Push when full and pop when empty are ignored; the producer watches o_full/o_count to stay in range.
module wb_fifo
  import cpu_types_pkg::wb_req_t;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type T          = wb_req_t,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  T                 i_push_dat,
  input  logic             i_pop,
  output T                 o_head_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  T                 r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Arbitrates ALU (priority, no backpressure) and load (valid/ready, buffered) writebacks onto one registered RF write port.
// One-cycle write latency; scoreboard drives a combinational decode stall and the write port is bypassed to operands.
module rf_writeback_ctrl
  import cpu_types_pkg::index_t;
  import cpu_types_pkg::word_t;
  import cpu_types_pkg::wb_req_t;
#(
  parameter int NREGS      = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   alu_wb_valid,
  input  index_t alu_wb_index,
  input  word_t  alu_wb_data,
  input  logic   mem_wb_valid,
  output logic   mem_wb_ready,
  input  index_t mem_wb_index,
  input  word_t  mem_wb_data,
  input  logic   issue_ld_valid,
  input  index_t issue_ld_index,
  input  index_t dec_rs1,
  input  index_t dec_rs2,
  input  index_t dec_rd,
  input  logic   dec_rd_valid,
  output word_t  rs1_data,
  output word_t  rs2_data,
  output logic   stall,
  output logic   reg_write,
  output index_t write_index,
  output word_t  write_data,
  output index_t read_index1,
  output index_t read_index2,
  input  word_t  read_data1,
  input  word_t  read_data2
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_req_t          w_alu_req;
  wb_req_t          w_mem_req;
  wb_req_t          w_head;
  wb_req_t          w_sel_req;
  logic             w_alu_wr;
  logic             w_mem_acc;
  logic             w_sel_vld;
  logic             w_sel_ld;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [NREGS-1:0] w_pending_nxt;

  logic             r_reg_write;
  index_t           r_write_index;
  word_t            r_write_data;
  logic [NREGS-1:0] r_pending;

  assign w_alu_req = '{idx: alu_wb_index, data: alu_wb_data};
  assign w_mem_req = '{idx: mem_wb_index, data: mem_wb_data};
  assign w_alu_wr  = alu_wb_valid && (alu_wb_index != '0);
  assign w_mem_acc = mem_wb_valid && mem_wb_ready;

  assign mem_wb_ready = (w_count < CNT_W'(FIFO_DEPTH));

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (wb_req_t)
  ) u_wb_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_mem_req),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // Null ALU writes never claim the port, so the buffer head can drain underneath them.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_ld  = 1'b0;
    w_bypass  = 1'b0;
    w_pop     = 1'b0;
    w_sel_req = w_alu_req;
    if (w_alu_wr) begin
      w_sel_vld = 1'b1;
    end else if (!w_empty) begin
      w_sel_vld = 1'b1;
      w_sel_ld  = 1'b1;
      w_pop     = 1'b1;
      w_sel_req = w_head;
    end else if (w_mem_acc) begin
      w_sel_vld = 1'b1;
      w_sel_ld  = 1'b1;
      w_bypass  = 1'b1;
      w_sel_req = w_mem_req;
    end
    w_push = w_mem_acc && !w_bypass && !w_full;
  end

  // A new issue outranks the clear of an older load to the same register.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_sel_ld) w_pending_nxt[w_sel_req.idx] = 1'b0;
    if (issue_ld_valid && (issue_ld_index != '0)) w_pending_nxt[issue_ld_index] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write   <= 1'b0;
      r_write_index <= '0;
      r_write_data  <= '0;
      r_pending     <= '0;
    end else begin
      r_reg_write <= w_sel_vld && (w_sel_req.idx != '0);
      if (w_sel_vld) begin
        r_write_index <= w_sel_req.idx;
        r_write_data  <= w_sel_req.data;
      end
      r_pending <= w_pending_nxt;
    end
  end

  assign reg_write   = r_reg_write;
  assign write_index = r_write_index;
  assign write_data  = r_write_data;

  assign read_index1 = dec_rs1;
  assign read_index2 = dec_rs2;

  assign stall = r_pending[dec_rs1] | r_pending[dec_rs2] | (dec_rd_valid & r_pending[dec_rd]);

  always_comb begin
    rs1_data = read_data1;
    rs2_data = read_data2;
    if (r_reg_write && (r_write_index == dec_rs1)) rs1_data = r_write_data;
    if (r_reg_write && (r_write_index == dec_rs2)) rs2_data = r_write_data;
    if (dec_rs1 == '0) rs1_data = '0;
    if (dec_rs2 == '0) rs2_data = '0;
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed and randomized checks of rf_writeback_ctrl against a queue/array reference model.
module tb_rf_writeback_ctrl;
  import cpu_types_pkg::*;

  localparam int DEPTH = 2;

  logic   clk = 1'b0;
  logic   rst;
  logic   alu_wb_valid, mem_wb_valid, mem_wb_ready, issue_ld_valid, dec_rd_valid;
  index_t alu_wb_index, mem_wb_index, issue_ld_index, dec_rs1, dec_rs2, dec_rd;
  word_t  alu_wb_data, mem_wb_data, rs1_data, rs2_data, write_data, read_data1, read_data2;
  logic   stall, reg_write;
  index_t write_index, read_index1, read_index2;

  word_t     m_rf [32];
  wb_req_t   q [$];
  bit [31:0] m_pend;
  logic      m_rw;
  index_t    m_widx;
  word_t     m_wdata;
  int        checks = 0;
  int        failures = 0;

  assign read_data1 = m_rf[read_index1];
  assign read_data2 = m_rf[read_index2];

  always #5 clk = ~clk;

  rf_writeback_ctrl #(.NREGS(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_index(alu_wb_index), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
    .mem_wb_index(mem_wb_index), .mem_wb_data(mem_wb_data),
    .issue_ld_valid(issue_ld_valid), .issue_ld_index(issue_ld_index),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_valid(dec_rd_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall),
    .reg_write(reg_write), .write_index(write_index), .write_data(write_data),
    .read_index1(read_index1), .read_index2(read_index2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic word_t exp_rs(input index_t r);
    if (r == 0) return '0;
    if (m_rw && m_widx == r) return m_wdata;
    return m_rf[r];
  endfunction

  // One clock cycle: drive at negedge, check operand side, advance model at posedge, check write port.
  task automatic step(input logic av, input index_t ai, input word_t ad,
                      input logic mv, input index_t mi, input word_t md,
                      input logic iv, input index_t ii,
                      input index_t r1, input index_t r2, input index_t rd, input logic rdv,
                      output logic acc);
    bit      accd, used, sel, ld;
    wb_req_t s;
    alu_wb_valid = av; alu_wb_index = ai; alu_wb_data = ad;
    mem_wb_valid = mv; mem_wb_index = mi; mem_wb_data = md;
    issue_ld_valid = iv; issue_ld_index = ii;
    dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd; dec_rd_valid = rdv;
    #1;
    chk("ready", 32'(mem_wb_ready), 32'(q.size() < DEPTH));
    chk("stall", 32'(stall), 32'(m_pend[r1] | m_pend[r2] | (rdv & m_pend[rd])));
    chk("rs1_data", rs1_data, exp_rs(r1));
    chk("rs2_data", rs2_data, exp_rs(r2));
    chk("read_index1", 32'(read_index1), 32'(r1));
    chk("read_index2", 32'(read_index2), 32'(r2));
    @(posedge clk);
    accd = mv && (q.size() < DEPTH);
    used = 0; sel = 0; ld = 0; s = '0;
    if (m_rw) m_rf[m_widx] = m_wdata;
    if (av && ai != 0) begin
      sel = 1; s.idx = ai; s.data = ad;
    end else if (q.size() > 0) begin
      sel = 1; ld = 1; s = q.pop_front();
    end else if (accd) begin
      sel = 1; ld = 1; used = 1; s.idx = mi; s.data = md;
    end
    if (accd && !used) begin
      wb_req_t n;
      n.idx = mi; n.data = md;
      q.push_back(n);
    end
    if (ld) m_pend[s.idx] = 1'b0;
    if (iv && ii != 0) m_pend[ii] = 1'b1;
    m_rw = sel && (s.idx != 0);
    if (sel) begin m_widx = s.idx; m_wdata = s.data; end
    acc = accd;
    #1;
    chk("reg_write", 32'(reg_write), 32'(m_rw));
    if (m_rw) begin
      chk("write_index", 32'(write_index), 32'(m_widx));
      chk("write_data", write_data, m_wdata);
    end
    chk("x0_write", 32'(reg_write && write_index == 0), 32'(0));
    @(negedge clk);
  endtask

  task automatic idle(input index_t r1, input index_t r2);
    logic a;
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 0, 0, a);
  endtask

  task automatic do_reset(input index_t r1);
    rst = 1'b1;
    alu_wb_valid = 0; mem_wb_valid = 0; issue_ld_valid = 0; dec_rd_valid = 0;
    alu_wb_index = 0; mem_wb_index = 0; issue_ld_index = 0;
    alu_wb_data = 0; mem_wb_data = 0;
    dec_rs1 = r1; dec_rs2 = 0; dec_rd = 0;
    q.delete(); m_pend = '0; m_rw = 1'b0; m_widx = '0; m_wdata = '0;
    #1;
    chk("rst_reg_write", 32'(reg_write), 32'(0));
    chk("rst_write_index", 32'(write_index), 32'(0));
    chk("rst_write_data", write_data, 32'(0));
    chk("rst_ready", 32'(mem_wb_ready), 32'(1));
    chk("rst_stall", 32'(stall), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic   off_v;
    index_t off_i;
    word_t  off_d;
    for (int i = 0; i < 32; i++) m_rf[i] = $urandom;
    do_reset(0);
    idle(0, 0);

    // ALU-only write and bypass
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    dec_rs1 = 5; #1;
    chk("alu_reg_write", 32'(reg_write), 32'(1));
    chk("alu_write_index", 32'(write_index), 32'(5));
    chk("alu_rs1_bypass", rs1_data, 32'hDEADBEEF);
    idle(5, 0);

    // Contention: ALU burst holds two loads in the buffer
    step(1, 3, 32'hA1, 1, 7, 32'h11, 0, 0, 0, 0, 0, 0, a);
    step(1, 3, 32'hA2, 1, 8, 32'h22, 0, 0, 0, 0, 0, 0, a);
    #1 chk("cont_ready_full", 32'(mem_wb_ready), 32'(0));
    step(1, 3, 32'hA3, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    #1 chk("cont_x7_index", 32'(write_index), 32'(7));
    chk("cont_x7_data", write_data, 32'h11);
    idle(7, 0);
    #1 chk("cont_x8_index", 32'(write_index), 32'(8));
    chk("cont_x8_data", write_data, 32'h22);
    idle(0, 0);

    // Scoreboard stall and release with bypass
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, a);
    idle(0, 9);
    #1 chk("sb_stall_set", 32'(stall), 32'(1));
    step(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 9, 0, 0, a);
    #1 chk("sb_stall_clear", 32'(stall), 32'(0));
    chk("sb_rs2_bypass", rs2_data, 32'h99);
    idle(0, 9);

    // Set/clear collision on x9
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, a);
    step(0, 0, 0, 1, 9, 32'h55, 1, 9, 0, 9, 0, 0, a);
    #1 chk("coll_stall", 32'(stall), 32'(1));
    chk("coll_write_index", 32'(write_index), 32'(9));
    step(0, 0, 0, 1, 9, 32'h66, 0, 0, 0, 9, 9, 1, a);
    idle(0, 9);

    // x0 ALU write does not block the buffered x4 load
    step(1, 1, 32'h1234, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, a);
    step(1, 0, 32'hBAD0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    dec_rs1 = 0; #1;
    chk("x0_reg_write", 32'(reg_write), 32'(1));
    chk("x0_buf_index", 32'(write_index), 32'(4));
    chk("x0_rs1_zero", rs1_data, 32'(0));
    idle(4, 0);

    // Reset mid-stream with two loads buffered and x9 pending
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, a);
    step(1, 2, 32'h20, 1, 10, 32'h10, 0, 0, 0, 0, 0, 0, a);
    step(1, 2, 32'h21, 1, 11, 32'h11, 0, 0, 0, 0, 0, 0, a);
    do_reset(9);
    for (int i = 0; i < 3; i++) idle(9, 10);

    // Randomized traffic; an unaccepted load offer is held until taken
    off_v = 0; off_i = 0; off_d = 0;
    for (int n = 0; n < 400; n++) begin
      logic   av, iv, rdv;
      index_t ai, ii, r1, r2, rd;
      word_t  ad;
      if (!off_v && ($urandom_range(0, 99) < 50)) begin
        off_v = 1; off_i = index_t'($urandom_range(0, 7)); off_d = $urandom;
      end
      av  = ($urandom_range(0, 99) < 45);
      ai  = index_t'($urandom_range(0, 7));
      ad  = $urandom;
      iv  = ($urandom_range(0, 99) < 25);
      ii  = index_t'($urandom_range(0, 7));
      r1  = index_t'($urandom_range(0, 7));
      r2  = index_t'($urandom_range(0, 7));
      rd  = index_t'($urandom_range(0, 7));
      rdv = $urandom_range(0, 1) == 1;
      step(av, ai, ad, off_v, off_i, off_d, iv, ii, r1, r2, rd, rdv, a);
      if (a) off_v = 0;
    end
    for (int i = 0; i < 4; i++) idle(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
